// File: rtl/draw_sequencer_if.sv
// Command/engine handshake bundle between a draw controller and the draw sequencer.
// The sequencer connects through the slave modport.
interface draw_sequencer_if;
  logic       CMD_VALID;
  logic [3:0] CMD_OP;
  logic       CMD_READY;
  logic       FU_REQ;
  logic [4:0] START;
  logic [4:0] DONE;
  logic       FU_START;
  logic       FU_DONE;
  logic [3:0] SEL;
  logic       BUSY;
  logic       ERR;
  logic       TIMEOUT;

  modport master (
    output CMD_VALID, CMD_OP, FU_REQ, DONE, FU_DONE,
    input  CMD_READY, START, FU_START, SEL, BUSY, ERR, TIMEOUT
  );

  modport slave (
    input  CMD_VALID, CMD_OP, FU_REQ, DONE, FU_DONE,
    output CMD_READY, START, FU_START, SEL, BUSY, ERR, TIMEOUT
  );
endinterface

// File: rtl/draw_sequencer.sv
// Draw sequencer: accepts draw/frame-update commands, launches one engine at a time
// and waits for its completion or abandons it after a timeout.
module draw_sequencer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
  input  logic            CLK,
  input  logic            RST,
  draw_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    FLAUNCH = 3'd3,
    FWAIT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_FU    = 4'd10;
  localparam logic [3:0] SEL_FU   = 4'd10;
  localparam logic [3:0] SEL_IDLE = 4'd15;

  state_t      state_r, next_state_s;
  logic [2:0]  op_r, op_next_s;
  logic [15:0] wait_cnt_r;
  logic        fu_pending_r;
  logic        illegal_s, timeout_s, expired_s;
  logic [4:0]  start_r, start_next_s;
  logic        fu_start_r, fu_start_next_s;
  logic [3:0]  sel_r, sel_next_s;
  logic        busy_r, busy_next_s;
  logic        err_r, timeout_r;

  function automatic logic [4:0] op_onehot(input logic [2:0] op);
    case (op)
      3'd0:    op_onehot = 5'b00001;
      3'd1:    op_onehot = 5'b00010;
      3'd2:    op_onehot = 5'b00100;
      3'd3:    op_onehot = 5'b01000;
      3'd4:    op_onehot = 5'b10000;
      default: op_onehot = 5'b00000;
    endcase
  endfunction

  assign expired_s = (wait_cnt_r == (TIMEOUT_CYCLES - 16'd1));

  // Next-state selection; a completion on the expiry cycle beats the timeout.
  always_comb begin
    next_state_s = state_r;
    op_next_s    = op_r;
    illegal_s    = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (fu_pending_r) begin
          next_state_s = FLAUNCH;
        end else if (bus.CMD_VALID) begin
          if (bus.CMD_OP <= 4'd4) begin
            next_state_s = LAUNCH;
            op_next_s    = bus.CMD_OP[2:0];
          end else if (bus.CMD_OP == OP_FU) begin
            next_state_s = FLAUNCH;
          end else begin
            illegal_s = 1'b1;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      LAUNCH:  next_state_s = WAIT;
      WAIT: begin
        if (|(bus.DONE & op_onehot(op_r))) begin
          next_state_s = IDLE;
        end else if (expired_s) begin
          next_state_s = IDLE;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = WAIT;
        end
      end
      FLAUNCH: next_state_s = FWAIT;
      FWAIT: begin
        if (bus.FU_DONE) begin
          next_state_s = IDLE;
        end else if (expired_s) begin
          next_state_s = IDLE;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = FWAIT;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered.
  always_comb begin
    start_next_s    = 5'b00000;
    fu_start_next_s = 1'b0;
    sel_next_s      = SEL_IDLE;
    busy_next_s     = 1'b1;
    case (next_state_s)
      IDLE:    busy_next_s = 1'b0;
      LAUNCH: begin
        start_next_s = op_onehot(op_next_s);
        sel_next_s   = {1'b0, op_next_s};
      end
      WAIT:    sel_next_s = {1'b0, op_next_s};
      FLAUNCH: begin
        fu_start_next_s = 1'b1;
        sel_next_s      = SEL_FU;
      end
      FWAIT:   sel_next_s = SEL_FU;
      default: busy_next_s = 1'b0;
    endcase
  end

  // State, wait counter, pending frame update and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= IDLE;
      op_r         <= 3'd0;
      wait_cnt_r   <= 16'd0;
      fu_pending_r <= 1'b0;
      start_r      <= 5'b00000;
      fu_start_r   <= 1'b0;
      sel_r        <= SEL_IDLE;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      op_r         <= op_next_s;
      wait_cnt_r   <= ((state_r == WAIT) || (state_r == FWAIT)) ? (wait_cnt_r + 16'd1) : 16'd0;
      // A new request in the same cycle as FLAUNCH entry keeps the flag set.
      fu_pending_r <= bus.FU_REQ | (fu_pending_r & (next_state_s != FLAUNCH));
      start_r      <= start_next_s;
      fu_start_r   <= fu_start_next_s;
      sel_r        <= sel_next_s;
      busy_r       <= busy_next_s;
      err_r        <= err_r | illegal_s | timeout_s;
      timeout_r    <= timeout_s;
    end
  end

  assign bus.CMD_READY = (state_r == IDLE) && !fu_pending_r && !RST;
  assign bus.START     = start_r;
  assign bus.FU_START  = fu_start_r;
  assign bus.SEL       = sel_r;
  assign bus.BUSY      = busy_r;
  assign bus.ERR       = err_r;
  assign bus.TIMEOUT   = timeout_r;
endmodule

// File: tb/tb_draw_sequencer.sv
// Randomized transaction-level bench for draw_sequencer with a short timeout.
// Expected outputs follow from each job's launch/wait/done timeline.
module tb_draw_sequencer;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  draw_sequencer_if bus_if ();

  draw_sequencer #(.TIMEOUT_CYCLES(16'd8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int checks_cnt = 0;
  int errors_cnt = 0;
  bit pend_m = 1'b0;
  bit err_m  = 1'b0;
  bit to_m   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] onehot(input int e);
    logic [4:0] v;
    v = 5'b00001;
    return v << e;
  endfunction

  function automatic logic [3:0] pick_op();
    int r;
    int x;
    r = $urandom_range(0, 9);
    if (r < 6) return 4'($urandom_range(0, 4));
    else if (r < 8) return 4'd10;
    x = $urandom_range(5, 14);
    if (x >= 10) x++;
    return 4'(x);
  endfunction

  task automatic check_outs(input string ph, input logic [4:0] st, input bit fst,
                            input logic [3:0] sel, input bit busy, input bit rdy);
    check({ph, ".START"},     32'(bus_if.START),     32'(st));
    check({ph, ".FU_START"},  32'(bus_if.FU_START),  32'(fst));
    check({ph, ".SEL"},       32'(bus_if.SEL),       32'(sel));
    check({ph, ".BUSY"},      32'(bus_if.BUSY),      32'(busy));
    check({ph, ".CMD_READY"}, 32'(bus_if.CMD_READY), 32'(rdy));
    check({ph, ".ERR"},       32'(bus_if.ERR),       32'(err_m));
    check({ph, ".TIMEOUT"},   32'(bus_if.TIMEOUT),   32'(to_m));
  endtask

  task automatic quiet();
    bus_if.CMD_VALID = 1'b0;
    bus_if.CMD_OP    = 4'($urandom);
    bus_if.FU_REQ    = 1'b0;
    bus_if.DONE      = 5'b00000;
    bus_if.FU_DONE   = 1'b0;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1;
      bus_if.CMD_VALID = 1'b1;
      bus_if.CMD_OP    = 4'd0;
      bus_if.FU_REQ    = 1'b1;
      bus_if.DONE      = 5'($urandom);
      bus_if.FU_DONE   = 1'b1;
      #1;
      check("rst.CMD_READY", 32'(bus_if.CMD_READY), 32'd0);
    end
    pend_m = 1'b0;
    err_m  = 1'b0;
    to_m   = 1'b0;
  endtask

  // One IDLE cycle: possibly offer a command; nxt 0 = stay idle, 1 = engine e, 2 = frame update.
  task automatic idle_cycle(output int nxt, output int e);
    logic [3:0] op;
    bit v, fr;
    @(negedge clk);
    rst = 1'b0;
    v  = ($urandom_range(0, 3) != 0);
    op = pick_op();
    fr = ($urandom_range(0, 7) == 0);
    bus_if.CMD_VALID = v;
    bus_if.CMD_OP    = op;
    bus_if.FU_REQ    = fr;
    bus_if.DONE      = 5'($urandom);
    bus_if.FU_DONE   = 1'($urandom);
    #1;
    check_outs("idle", 5'd0, 1'b0, 4'd15, 1'b0, !pend_m);
    to_m = 1'b0;
    nxt  = 0;
    e    = 0;
    if (pend_m) nxt = 2;
    else if (v) begin
      if (op <= 4'd4) begin
        nxt = 1;
        e   = int'(op);
      end else if (op == 4'd10) nxt = 2;
      else err_m = 1'b1;
    end
    if (fr) pend_m = 1'b1;
    else if (nxt == 2) pend_m = 1'b0;
  endtask

  // Launch cycle plus wait window; done arrives at wait index d, or the job times out.
  task automatic run_job(input bit fu, input int e);
    int d, last;
    bit fr;
    logic [3:0] sel_e;
    d     = $urandom_range(0, T + 2);
    last  = (d <= T - 1) ? d : T - 1;
    sel_e = fu ? 4'd10 : 4'(e);
    @(negedge clk);
    fr = ($urandom_range(0, 7) == 0);
    bus_if.CMD_VALID = 1'($urandom);
    bus_if.CMD_OP    = pick_op();
    bus_if.FU_REQ    = fr;
    bus_if.DONE      = 5'($urandom);
    bus_if.FU_DONE   = 1'($urandom);
    #1;
    check_outs(fu ? "flaunch" : "launch", fu ? 5'd0 : onehot(e), fu, sel_e, 1'b1, 1'b0);
    if (fr) pend_m = 1'b1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      fr = ($urandom_range(0, 7) == 0);
      bus_if.CMD_VALID = 1'($urandom);
      bus_if.CMD_OP    = pick_op();
      bus_if.FU_REQ    = fr;
      if (fu) begin
        bus_if.DONE    = 5'b00000;
        bus_if.FU_DONE = (k == d);
      end else begin
        bus_if.DONE    = (5'($urandom) & ~onehot(e)) | ((k == d) ? onehot(e) : 5'd0);
        bus_if.FU_DONE = 1'b0;
      end
      #1;
      check_outs(fu ? "fwait" : "wait", 5'd0, 1'b0, sel_e, 1'b1, 1'b0);
      if (fr) pend_m = 1'b1;
    end
    if (d > T - 1) begin
      to_m  = 1'b1;
      err_m = 1'b1;
    end
  endtask

  initial begin
    int nxt, e;
    quiet();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_if.FU_REQ = 1'b1;
      #1;
      check_outs("reset", 5'd0, 1'b0, 4'd15, 1'b0, 1'b0);
    end
    for (int n = 0; n < 300; n++) begin
      idle_cycle(nxt, e);
      if (nxt == 1) run_job(1'b0, e);
      else if (nxt == 2) run_job(1'b1, 0);
    end

    // Reset in the middle of an op-3 wait, then a late DONE[3].
    do_reset(2);
    @(negedge clk);
    rst = 1'b0;
    quiet();
    bus_if.CMD_VALID = 1'b1;
    bus_if.CMD_OP    = 4'd3;
    #1;
    check_outs("mid.accept", 5'd0, 1'b0, 4'd15, 1'b0, 1'b1);
    @(negedge clk);
    quiet();
    #1;
    check_outs("mid.launch", 5'b01000, 1'b0, 4'd3, 1'b1, 1'b0);
    @(negedge clk);
    quiet();
    #1;
    check_outs("mid.wait", 5'd0, 1'b0, 4'd3, 1'b1, 1'b0);
    do_reset(1);
    @(negedge clk);
    rst = 1'b0;
    quiet();
    bus_if.DONE = 5'b01000;
    #1;
    check_outs("mid.late_done", 5'd0, 1'b0, 4'd15, 1'b0, 1'b1);
    @(negedge clk);
    quiet();
    #1;
    check_outs("mid.after", 5'd0, 1'b0, 4'd15, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule

// File: doc/draw_sequencer.md
DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 16'd65535: the maximum number of WAIT cycles before an engine is abandoned.
REQ-002 The module SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port CMD_VALID, input, 1 bit: a command is offered.
REQ-005 The module SHALL have port CMD_OP, input, 4 bits: opcode (0 CF, 1 CD, 2 RF, 3 RD, 4 LD, 10 FU); valid when CMD_VALID=1.
REQ-006 The module SHALL have port CMD_READY, output, 1 bit: the command is accepted on a cycle with CMD_VALID && CMD_READY.
REQ-007 The module SHALL have port FU_REQ, input, 1 bit: frame-update request (e.g. vsync); a single-cycle pulse is sufficient.
REQ-008 The module SHALL have port START, output, 5 bits: one-hot single-cycle launch pulse, bit n = engine opcode n (0..4).
REQ-009 The module SHALL have port DONE, input, 5 bits: engine completion, bit n = engine n.
REQ-010 The module SHALL have port FU_START, output, 1 bit: single-cycle frame-update launch pulse.
REQ-011 The module SHALL have port FU_DONE, input, 1 bit: frame-update completion.
REQ-012 The module SHALL have port SEL, output, 4 bits: coordinate-mux select code (0..4, 10, or 15 = IDLE).
REQ-013 The module SHALL have port BUSY, output, 1 bit: high whenever not in IDLE.
REQ-014 The module SHALL have port ERR, output, 1 bit: sticky error flag (illegal opcode or timeout).
REQ-015 The module SHALL have port TIMEOUT, output, 1 bit: single-cycle pulse when an engine is abandoned.

Function
REQ-016 The FSM SHALL have states IDLE, LAUNCH, WAIT, FLAUNCH and FWAIT; all outputs except CMD_READY SHALL be registered.
REQ-017 fu_pending SHALL be set on any cycle with FU_REQ=1, in any state, and cleared on entry to FLAUNCH; set has priority when both occur in the same cycle.
REQ-018 CMD_READY SHALL equal (state==IDLE) && !fu_pending && !RST.
REQ-019 In IDLE with fu_pending=1, the FSM SHALL go to FLAUNCH on the next cycle; a pending frame update always beats a new command.
REQ-020 On acceptance of opcode 0..4, the FSM SHALL latch op and go to LAUNCH.
REQ-021 On acceptance of opcode 10, the FSM SHALL go to FLAUNCH.
REQ-022 On acceptance of any other opcode, the command SHALL be dropped, ERR set, and the FSM SHALL stay in IDLE.
REQ-023 LAUNCH SHALL last exactly one cycle, with START[op]=1, SEL=op and BUSY=1, then go to WAIT.
REQ-024 In WAIT, SEL SHALL hold op; on DONE[op]=1 the FSM SHALL go to IDLE and SEL SHALL be 15 from the next cycle; other DONE bits SHALL be ignored.
REQ-025 FLAUNCH/FWAIT SHALL behave as LAUNCH/WAIT using FU_START, FU_DONE and SEL=10.
REQ-026 Latency SHALL be: accept at cycle N -> START at N+1 -> WAIT from N+2; DONE at cycle M -> IDLE with CMD_READY=1 at M+1, so the next accept is possible at M+1.
REQ-027 A 16-bit wait counter SHALL clear on entry to WAIT/FWAIT and increment each WAIT/FWAIT cycle.
REQ-028 When the wait counter reaches TIMEOUT_CYCLES-1 with no done, the block SHALL pulse TIMEOUT, set ERR, and go to IDLE (SEL=15).
REQ-029 DONE/FU_DONE asserted in the same cycle as the timeout SHALL win: completion is normal, with no TIMEOUT and no ERR.
REQ-030 DONE and FU_DONE SHALL be ignored in IDLE, LAUNCH and FLAUNCH.
REQ-031 ERR SHALL clear only on RST.

Reset
REQ-032 While RST=1 at a rising edge, state SHALL go to IDLE, SEL=15, START=0, FU_START=0, BUSY=0, ERR=0, TIMEOUT=0, fu_pending=0, and the wait counter SHALL be 0; CMD_READY=0 while RST=1.
REQ-033 A reset mid-operation SHALL abort the engine sequence with no further START pulse; a late DONE arriving after reset SHALL be ignored.
REQ-034 CMD_READY SHALL be 1 on the first cycle after RST falls.

Verification
REQ-035 Accept op=2 at cycle 10 -> START=5'b00100 at 11 only; SEL=2 over cycles 11..; DONE[2] at 20 -> SEL=15, BUSY=0, CMD_READY=1 at 21.
REQ-036 FU_REQ pulse during WAIT of op=4 -> after DONE[4], CMD_READY stays 0, FU_START pulses one cycle later with SEL=10; FU_DONE returns to IDLE.
REQ-037 FU_REQ and CMD_VALID(op=1) in the same IDLE cycle with fu_pending=0 -> command accepted, circle draw runs, frame update follows.
REQ-038 CMD_OP=7 accepted -> ERR=1, no START, state IDLE; ERR persists until RST.
REQ-039 TIMEOUT_CYCLES=8, op=0, DONE withheld -> TIMEOUT pulse exactly 8 WAIT cycles after entering WAIT, ERR=1, SEL=15.
REQ-040 Same timeout setup with DONE[0] on the expiry cycle -> no TIMEOUT, ERR=0.
REQ-041 RST during WAIT, then DONE[3] the cycle after -> IDLE, SEL=15, START=0, ERR=0.
